seq_scan_ctrl: RTL

- Byte-stream front end and sequencer for a serial "1011" pattern detector.
- Accepts bytes over a valid/ready handshake and serialises each byte MSB-first, one bit per clock, into an embedded Mealy detector.
- Counts matches per frame and raises an interrupt when a programmable threshold is reached.
- Sits between a byte-wide source (UART/FIFO) and CPU-visible status.

---
 rtl/seq_scan_pkg.sv | 28 ++
 rtl/seq_scan_ctrl_if.sv | 36 +++
 rtl/seq_bit_det.sv | 69 ++++++
 rtl/seq_scan_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// -----------------------------------------------------------------------------
// seq_scan_pkg
// Shared types for the "1011" byte-stream scanner:
//   ctrl_state_t : sequencer states (IDLE, LOAD, SHIFT, DONE)
//   det_state_t  : bit detector states (D_IDLE, D_1, D_10, D_101)
//   PATTERN      : the serial pattern being searched for, first bit in bit 3
// -----------------------------------------------------------------------------
package seq_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOAD  = 2'b01,
      SHIFT = 2'b10,
      DONE  = 2'b11
   } ctrl_state_t;

   // Each state names the longest pattern prefix seen so far.
   typedef enum logic [1:0] {
      D_IDLE = 2'b00,
      D_1    = 2'b01,
      D_10   = 2'b10,
      D_101  = 2'b11
   } det_state_t;

   // "1011", received MSB-first: PATTERN[3] is the first bit on the wire.
   localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seq_scan_ctrl_if
// Byte-wide valid/ready stream feeding the scanner.
//   byte_valid : source has a word on byte_in
//   byte_in    : data word (DATA_W bits)
//   byte_last  : qualifies byte_in as the final word of the frame
//   byte_ready : sink can accept a word
// Handshake: a word transfers on a rising clk edge where byte_valid and
// byte_ready are both 1. While byte_ready is 0 the source may change
// byte_in/byte_last freely; the sink ignores byte_valid in that case.
// Modports: master = source side, slave = scanner side.
// -----------------------------------------------------------------------------
interface seq_scan_ctrl_if #(
   parameter int DATA_W = 8
);

   logic              byte_valid;
   logic [DATA_W-1:0] byte_in;
   logic              byte_last;
   logic              byte_ready;

   modport master (
      output byte_valid,
      output byte_in,
      output byte_last,
      input  byte_ready
   );

   modport slave (
      input  byte_valid,
      input  byte_in,
      input  byte_last,
      output byte_ready
   );

endinterface

// File: rtl/seq_bit_det.sv
// -----------------------------------------------------------------------------
// seq_bit_det
// Mealy detector for the serial pattern "1011".
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return to D_IDLE (has priority over en)
//   en         : consume bit_in this cycle; state holds when low
//   bit_in     : serial data bit
//   match      : combinational, 1 when the current bit completes the pattern
//   state_dbg  : current detector state
// Build option: SEQ_OVERLAP_EN defined -> after a match continue from D_1 so
// overlapping occurrences count; undefined -> restart from D_IDLE.
// -----------------------------------------------------------------------------
module seq_bit_det
   import seq_scan_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic       match,
   output det_state_t state_dbg
);

   det_state_t state;
   det_state_t state_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= D_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // On a mismatching bit, fall back to the longest suffix that is still a
   // prefix of "1011" (KMP-style failure transitions).
   always_comb begin
      state_next = state;
      match      = 1'b0;
      if (clr) begin
         state_next = D_IDLE;
      end else if (en) begin
         case (state)
            D_IDLE:  state_next = (bit_in == PATTERN[3]) ? D_1   : D_IDLE;
            D_1:     state_next = (bit_in == PATTERN[2]) ? D_10  : D_1;
            D_10:    state_next = (bit_in == PATTERN[1]) ? D_101 : D_IDLE;
            D_101: begin
               if (bit_in == PATTERN[0]) begin
                  match = 1'b1;
`ifdef SEQ_OVERLAP_EN
                  // trailing '1' of the match starts the next occurrence
                  state_next = D_1;
`else
                  state_next = D_IDLE;
`endif
               end else begin
                  state_next = D_10;
               end
            end
            default: state_next = D_IDLE;
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: rtl/seq_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seq_scan_ctrl
// Accepts words over a valid/ready stream, shifts each one MSB-first into a
// "1011" detector (one bit per clock), counts matches per frame and pulses
// irq when the count first reaches a programmable threshold.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : one-cycle pulse, begins a frame; ignored unless idle
//   src          : slave side of the byte stream (byte_valid/in/last/ready)
//   match_thresh : irq threshold, sampled at start; 0 disables irq
//   busy         : frame in progress (LOAD, SHIFT, DONE)
//   done         : one-cycle pulse after the last bit of the last word
//   match_cnt    : saturating match count of current/last frame
//   irq          : one-cycle pulse when match_cnt first equals threshold
//   ctrl_state   : sequencer state, for observation
//   det_state    : detector state, for observation
// Build option: SEQ_OVERLAP_EN (overlapping matches, see seq_bit_det).
// Throughput: DATA_W+1 cycles per word (one LOAD + DATA_W SHIFT cycles).
// -----------------------------------------------------------------------------
module seq_scan_ctrl
   import seq_scan_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int DATA_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   seq_scan_ctrl_if.slave   src,
   input  logic [CNT_W-1:0] match_thresh,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] match_cnt,
   output logic             irq,
   output ctrl_state_t      ctrl_state,
   output det_state_t       det_state
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   ctrl_state_t       state;
   ctrl_state_t       state_next;
   logic [DATA_W-1:0] shreg;
   logic [IDX_W-1:0]  idx;
   logic              last_q;
   logic [CNT_W-1:0]  thresh_q;
   logic              irq_fired;

   logic              ready;
   logic              det_clr;
   logic              det_en;
   logic              det_match;
   logic              bit_cur;
   logic [CNT_W-1:0]  cnt_inc;

   assign bit_cur        = shreg[idx];
   assign cnt_inc        = match_cnt + CNT_W'(1);
   assign src.byte_ready = ready;
   assign ctrl_state     = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      ready      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      det_clr    = 1'b0;
      det_en     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               det_clr    = 1'b1;
               state_next = LOAD;
            end
         end
         LOAD: begin
            ready = 1'b1;
            busy  = 1'b1;
            if (src.byte_valid) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy   = 1'b1;
            det_en = 1'b1;
            if (idx == '0) begin
               state_next = last_q ? DONE : LOAD;
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg     <= '0;
         idx       <= '0;
         last_q    <= 1'b0;
         thresh_q  <= '0;
         match_cnt <= '0;
         irq       <= 1'b0;
         irq_fired <= 1'b0;
      end else begin
         irq <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  match_cnt <= '0;
                  thresh_q  <= match_thresh;
                  irq_fired <= 1'b0;
               end
            end
            LOAD: begin
               if (src.byte_valid) begin
                  shreg  <= src.byte_in;
                  last_q <= src.byte_last;
                  idx    <= IDX_W'(DATA_W - 1);
               end
            end
            SHIFT: begin
               if (idx != '0) begin
                  idx <= idx - IDX_W'(1);
               end
               // Saturate: once at all-ones further matches change nothing,
               // so irq cannot retrigger there either.
               if (det_match && (match_cnt != '1)) begin
                  match_cnt <= cnt_inc;
                  if ((thresh_q != '0) && (cnt_inc == thresh_q) && !irq_fired) begin
                     irq       <= 1'b1;
                     irq_fired <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   seq_bit_det u_det (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (det_clr),
      .en        (det_en),
      .bit_in    (bit_cur),
      .match     (det_match),
      .state_dbg (det_state)
   );

endmodule
